// File: rtl/iddr_deser_bank.sv
// iddr_deser_bank: multi-lane SDR/DDR input deserializer.
// Each lane shifts in 1 or 2 pre-captured bits per clock and frames them
// MSB-first into DATA_WIDTH-bit words. A per-lane bitslip moves the word
// boundary. A single strobe marks the cycle in which all lanes present new words.
module iddr_deser_bank #(
  parameter int LANES         = 1,
  parameter int DATA_WIDTH    = 8,
  parameter     DATA_RATE     = "DDR",
  parameter bit IS_C_INVERTED = 1'b0
) (
  input  logic                        C,
  input  logic                        R,
  input  logic                        CE,
  input  logic [LANES-1:0]            D,
  input  logic [LANES-1:0]            DB,
  input  logic [LANES-1:0]            BITSLIP,
  output logic [LANES*DATA_WIDTH-1:0] Q,
  output logic                        Q_VALID
);

  localparam int W     = DATA_WIDTH;
  localparam int B     = (DATA_RATE == "SDR") ? 1 : 2;
  localparam int N     = W / B;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int OFF_W = (W > 1) ? $clog2(W) : 1;
  // The capture window never reaches past bit 2W-2 of the post-shift
  // history, so only the bits that can still land in a window are stored.
  localparam int WIN_W  = 2 * W - 1;
  localparam int HIST_W = WIN_W - B;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(W - 1);

  // Every register in the block shares this edge, so inverting C here moves
  // the whole deserializer onto the falling edge.
  logic clk_int;
  assign clk_int = C ^ IS_C_INVERTED;

  logic [CNT_W-1:0] cnt;
  logic             capture;

  assign capture = CE && (cnt == CNT_LAST);

  // Shared word counter and the word-valid strobe.
  always_ff @(posedge clk_int) begin
    if (R) begin
      cnt     <= '0;
      Q_VALID <= 1'b0;
    end else begin
      Q_VALID <= capture;
      if (CE) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [HIST_W-1:0] hist;
    logic [WIN_W-1:0]  hist_next;
    logic [OFF_W-1:0]  off;
    logic              lock;
    logic [W-1:0]      word;
    logic              slip_ok;

    if (B == 2) begin : g_ddr
      assign hist_next = {hist, D[i], DB[i]};
    end else begin : g_sdr
      logic unused_db;
      assign unused_db = DB[i];
      assign hist_next = {hist, D[i]};
    end

    // lock limits a lane to one accepted slip per word period.
    assign slip_ok = CE && BITSLIP[i] && !lock;

    // Per-lane history, alignment offset, slip lock and captured word.
    always_ff @(posedge clk_int) begin
      if (R) begin
        hist <= '0;
        off  <= '0;
        lock <= 1'b0;
        word <= '0;
      end else if (CE) begin
        hist <= hist_next[HIST_W-1:0];
        if (capture) begin
          word <= hist_next[off +: W];
        end
        if (slip_ok) begin
          off <= (off == OFF_LAST) ? '0 : off + 1'b1;
        end
        if (capture) begin
          lock <= 1'b0;
        end else if (slip_ok) begin
          lock <= 1'b1;
        end
      end
    end

    assign Q[i*W +: W] = word;
  end

endmodule

// File: tb/tb_iddr_deser_bank.sv
// Testbench for iddr_deser_bank: a DDR 2-lane W=8 instance and an SDR 1-lane
// W=4 instance, checked against a bit-stream reference model.
module tb_iddr_deser_bank;

  logic C = 1'b0;
  always #5 C = ~C;

  logic        r0, ce0;
  logic [1:0]  d0, db0, bs0;
  logic [15:0] q0;
  logic        v0;

  logic        r1, ce1;
  logic [0:0]  d1, db1, bs1;
  logic [3:0]  q1;
  logic        v1;

  iddr_deser_bank #(.LANES(2), .DATA_WIDTH(8), .DATA_RATE("DDR"), .IS_C_INVERTED(1'b0)) dut_ddr (
    .C(C), .R(r0), .CE(ce0), .D(d0), .DB(db0), .BITSLIP(bs0), .Q(q0), .Q_VALID(v0)
  );

  iddr_deser_bank #(.LANES(1), .DATA_WIDTH(4), .DATA_RATE("SDR"), .IS_C_INVERTED(1'b0)) dut_sdr (
    .C(C), .R(r1), .CE(ce1), .D(d1), .DB(db1), .BITSLIP(bs1), .Q(q1), .Q_VALID(v1)
  );

  int checks = 0;
  int passed = 0;
  int ph0 = 0;
  int ph1 = 0;

  // Reference model: every bit received since reset, per lane, in arrival
  // order. A word is the W bits ending 'off' bits before the newest one.
  localparam int MAXB = 8192;
  logic       mb    [2][2][MAXB];
  int         ml    [2][2];
  int         mcnt  [2];
  int         moff  [2][2];
  bit         mlock [2][2];
  logic [7:0] mq    [2][2];
  bit         mv    [2];

  function automatic logic [7:0] model_word(int d, int ln, int w);
    logic [7:0] r;
    r = '0;
    for (int j = 0; j < w; j++) begin
      int idx;
      idx = ml[d][ln] - 1 - moff[d][ln] - j;
      if (idx >= 0) r[j] = mb[d][ln][idx];
    end
    return r;
  endfunction

  task automatic model_push(int d, int ln, logic b);
    if (ml[d][ln] < MAXB) begin
      mb[d][ln][ml[d][ln]] = b;
      ml[d][ln]++;
    end
  endtask

  task automatic model_step(int d, int w, int b, int lanes, logic r, logic ce,
                            logic [1:0] dv, logic [1:0] dbv, logic [1:0] bs);
    int n;
    bit cap;
    bit acc;
    n = w / b;
    if (r) begin
      mcnt[d] = 0;
      mv[d]   = 0;
      for (int ln = 0; ln < 2; ln++) begin
        ml[d][ln] = 0; moff[d][ln] = 0; mlock[d][ln] = 0; mq[d][ln] = '0;
      end
    end else if (!ce) begin
      mv[d] = 0;
    end else begin
      cap = (mcnt[d] == n - 1);
      for (int ln = 0; ln < lanes; ln++) begin
        model_push(d, ln, dv[ln]);
        if (b == 2) model_push(d, ln, dbv[ln]);
        if (cap) mq[d][ln] = model_word(d, ln, w);
        acc = bs[ln] && !mlock[d][ln];
        if (acc) moff[d][ln] = (moff[d][ln] + 1) % w;
        if (cap) mlock[d][ln] = 0;
        else if (acc) mlock[d][ln] = 1;
      end
      mcnt[d] = cap ? 0 : mcnt[d] + 1;
      mv[d]   = cap;
    end
  endtask

  task automatic tick();
    model_step(0, 8, 2, 2, r0, ce0, d0, db0, bs0);
    model_step(1, 4, 1, 1, r1, ce1, {1'b0, d1}, {1'b0, db1}, {1'b0, bs1});
    if (r0) ph0 = 0; else if (ce0) ph0++;
    if (r1) ph1 = 0; else if (ce1) ph1++;
    @(posedge C);
    #1;
  endtask

  // Lane0 (D,DB) = (1,0),(1,0),(0,1),(0,1) repeating; lane1 inverted.
  task automatic set_ddr_pattern();
    logic l0;
    l0  = ((ph0 % 4) < 2);
    d0  = {~l0, l0};
    db0 = {l0, ~l0};
  endtask

  task automatic test_reset();
    r0 = 1; ce0 = 1; d0 = 2'b11; db0 = 2'b11; bs0 = 2'b11;
    r1 = 1; ce1 = 1; d1 = 1'b1;  db1 = 1'b1;  bs1 = 1'b1;
    tick();
    tick();
    checks++;
    if (q0 !== 16'h0000 || v0 !== 1'b0) $display("FAIL reset_ddr: got q=%h v=%b, want q=0000 v=0", q0, v0);
    else passed++;
    checks++;
    if (q1 !== 4'h0 || v1 !== 1'b0) $display("FAIL reset_sdr: got q=%h v=%b, want q=0 v=0", q1, v1);
    else passed++;
  endtask

  task automatic test_ddr_stream();
    int first;
    first = -1;
    r0 = 0; ce0 = 1; bs0 = 2'b00;
    for (int c = 1; c <= 16; c++) begin
      set_ddr_pattern();
      tick();
      checks++;
      if (q0 !== {mq[0][1], mq[0][0]} || v0 !== mv[0])
        $display("FAIL ddr_stream c%0d: got q=%h v=%b, want q=%h v=%b", c, q0, v0, {mq[0][1], mq[0][0]}, mv[0]);
      else passed++;
      if (v0 && first < 0) first = c;
      if (v0) begin
        checks++;
        if (q0 !== 16'h5AA5) $display("FAIL ddr_word c%0d: got q=%h, want q=5aa5", c, q0);
        else passed++;
      end
    end
    checks++;
    if (first != 4) $display("FAIL ddr_first_valid: got cycle %0d, want cycle 4", first);
    else passed++;
  endtask

  task automatic test_bitslip();
    for (int k = 0; k < 8; k++) begin
      for (int p = 0; p < 4; p++) begin
        set_ddr_pattern();
        bs0 = (p == 1) ? 2'b01 : 2'b00;
        tick();
        checks++;
        if (q0 !== {mq[0][1], mq[0][0]} || v0 !== mv[0])
          $display("FAIL bitslip k%0d p%0d: got q=%h v=%b, want q=%h v=%b", k, p, q0, v0, {mq[0][1], mq[0][0]}, mv[0]);
        else passed++;
        if (p == 3 && k == 0) begin
          checks++;
          if (q0 !== 16'h5AD2 || v0 !== 1'b1) $display("FAIL bitslip_one: got q=%h v=%b, want q=5ad2 v=1", q0, v0);
          else passed++;
        end
        if (p == 3 && k == 7) begin
          checks++;
          if (q0 !== 16'h5AA5 || v0 !== 1'b1) $display("FAIL bitslip_wrap: got q=%h v=%b, want q=5aa5 v=1", q0, v0);
          else passed++;
        end
      end
    end
    bs0 = 2'b00;
  endtask

  task automatic test_slip_lock();
    for (int p = 0; p < 8; p++) begin
      set_ddr_pattern();
      bs0 = (p < 4) ? 2'b01 : 2'b00;
      tick();
      checks++;
      if (q0 !== {mq[0][1], mq[0][0]} || v0 !== mv[0])
        $display("FAIL slip_lock p%0d: got q=%h v=%b, want q=%h v=%b", p, q0, v0, {mq[0][1], mq[0][0]}, mv[0]);
      else passed++;
      if (p == 3 || p == 7) begin
        checks++;
        if (q0 !== 16'h5AD2 || v0 !== 1'b1) $display("FAIL slip_lock_word p%0d: got q=%h v=%b, want q=5ad2 v=1", p, q0, v0);
        else passed++;
      end
    end
    bs0 = 2'b00;
  endtask

  task automatic test_ce_gating();
    ce0 = 1;
    for (int p = 0; p < 2; p++) begin
      set_ddr_pattern();
      tick();
    end
    ce0 = 0;
    for (int g = 0; g < 3; g++) begin
      d0 = 2'($urandom); db0 = 2'($urandom); bs0 = 2'($urandom);
      tick();
      checks++;
      if (q0 !== 16'h5AD2 || v0 !== 1'b0 || q0 !== {mq[0][1], mq[0][0]})
        $display("FAIL ce_hold g%0d: got q=%h v=%b, want q=5ad2 v=0", g, q0, v0);
      else passed++;
    end
    ce0 = 1; bs0 = 2'b00;
    for (int p = 2; p < 4; p++) begin
      set_ddr_pattern();
      tick();
      checks++;
      if (q0 !== {mq[0][1], mq[0][0]} || v0 !== mv[0])
        $display("FAIL ce_resume p%0d: got q=%h v=%b, want q=%h v=%b", p, q0, v0, {mq[0][1], mq[0][0]}, mv[0]);
      else passed++;
    end
    checks++;
    if (q0 !== 16'h5AD2 || v0 !== 1'b1) $display("FAIL ce_word: got q=%h v=%b, want q=5ad2 v=1", q0, v0);
    else passed++;
  endtask

  task automatic test_sdr();
    logic [3:0] pat;
    pat = 4'b1101;
    ce0 = 0;
    r1 = 1; tick();
    r1 = 0; ce1 = 1; bs1 = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      d1  = pat[ph1 % 4];
      db1 = 1'($urandom);
      tick();
      checks++;
      if (q1 !== mq[1][0][3:0] || v1 !== mv[1])
        $display("FAIL sdr c%0d: got q=%h v=%b, want q=%h v=%b", c, q1, v1, mq[1][0][3:0], mv[1]);
      else passed++;
      checks++;
      if (c % 4 == 0) begin
        if (q1 !== 4'hB || v1 !== 1'b1) $display("FAIL sdr_word c%0d: got q=%h v=%b, want q=b v=1", c, q1, v1);
        else passed++;
      end else begin
        if (v1 !== 1'b0) $display("FAIL sdr_gap c%0d: got v=%b, want v=0", c, v1);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid();
    ce0 = 1; bs0 = 2'b00;
    r0 = 1; tick();
    r0 = 0;
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 4; p++) begin
        set_ddr_pattern();
        bs0 = (p == 1) ? 2'b01 : 2'b00;
        tick();
      end
    end
    bs0 = 2'b00;
    for (int p = 0; p < 2; p++) begin
      set_ddr_pattern();
      tick();
    end
    checks++;
    if (q0 !== {mq[0][1], mq[0][0]} || q0 === 16'h0000)
      $display("FAIL pre_reset_word: got q=%h, want q=%h", q0, {mq[0][1], mq[0][0]});
    else passed++;
    r0 = 1; bs0 = 2'b01;
    set_ddr_pattern();
    tick();
    checks++;
    if (q0 !== 16'h0000 || v0 !== 1'b0) $display("FAIL reset_mid: got q=%h v=%b, want q=0000 v=0", q0, v0);
    else passed++;
    r0 = 0; bs0 = 2'b00;
    for (int c = 1; c <= 4; c++) begin
      set_ddr_pattern();
      tick();
      checks++;
      if (c < 4) begin
        if (v0 !== 1'b0) $display("FAIL reset_mid_gap c%0d: got v=%b, want v=0", c, v0);
        else passed++;
      end else begin
        if (q0 !== 16'h5AA5 || v0 !== 1'b1) $display("FAIL reset_mid_word: got q=%h v=%b, want q=5aa5 v=1", q0, v0);
        else passed++;
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      r0  = ($urandom_range(0, 49) == 0);
      ce0 = ($urandom_range(0, 3) != 0);
      d0  = 2'($urandom); db0 = 2'($urandom);
      bs0 = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      r1  = ($urandom_range(0, 49) == 0);
      ce1 = ($urandom_range(0, 3) != 0);
      d1  = 1'($urandom); db1 = 1'($urandom); bs1 = 1'($urandom);
      tick();
      checks++;
      if (q0 !== {mq[0][1], mq[0][0]} || v0 !== mv[0])
        $display("FAIL random_ddr c%0d: got q=%h v=%b, want q=%h v=%b", c, q0, v0, {mq[0][1], mq[0][0]}, mv[0]);
      else passed++;
      checks++;
      if (q1 !== mq[1][0][3:0] || v1 !== mv[1])
        $display("FAIL random_sdr c%0d: got q=%h v=%b, want q=%h v=%b", c, q1, v1, mq[1][0][3:0], mv[1]);
      else passed++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_ddr_stream();
    test_bitslip();
    test_slip_lock();
    test_ce_gating();
    test_sdr();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
